aes_latch_arbiter: RTL and testbench
====================================

Name: aes_latch_arbiter

Overview:
- Shares one AES 128-bit block latch and its downstream AES core among NUM_REQ requesters.
- Grants requesters round-robin and loads the winner's block into the latch, then pulses core start.
- Waits for core completion, hands the result to the consumer with a tag, then clears the latch.
- Sits between the host/mode-chaining sources and the latch + round-core datapath.

Parameters:
- WIDTH, 128, block width in bits.
- NUM_REQ, 2, number of requesters (2..8).
- TAG_W, $clog2(NUM_REQ), requester tag width (derived; not overridden).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester block valid.
- req_data_i  input  NUM_REQ*WIDTH  flattened blocks; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready_o  output  NUM_REQ  per-requester accept, one-hot or zero.
- latch_d_o  output  WIDTH  registered block to latch d_i.
- latch_valid_o  output  1  latch load strobe.
- latch_clear_o  output  1  latch clear strobe.
- core_start_o  output  1  one-cycle core start pulse.
- core_done_i  input  1  core completion pulse.
- out_valid_o  output  1  result available; data is read from the latch output.
- out_ready_i  input  1  consumer accept.
- out_tag_o  output  TAG_W  requester index of the current result.
- flush_i  input  1  synchronous abort.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, rr pointer=0, latch_d_o=0, tag=0. All strobes, req_ready_o and out_valid_o are 0.
- Arbitration (IDLE only, combinational): scan requesters starting at (last_grant+1) mod NUM_REQ. The first requester with req_valid_i set gets req_ready_o=1.
- Handshake: req_valid_i[g] & req_ready_o[g] in the same cycle. On handshake:
  - latch_d_o <= block g; tag <= g; last_grant <= g.
  - Transition to LOAD.
- States, one per cycle unless noted:
  - IDLE: waits for a handshake.
  - LOAD: latch_valid_o=1 -> START.
  - START: core_start_o=1 -> WAIT.
  - WAIT: holds until core_done_i=1 -> OUT. core_done_i is sampled only in WAIT and ignored in all other states.
  - OUT: out_valid_o=1 and out_tag_o=tag, both held stable until out_ready_i=1 -> CLEAR.
  - CLEAR: latch_clear_o=1 -> IDLE.
- Minimum period is 6 cycles per block: handshake, LOAD, START, one WAIT cycle, one OUT cycle, CLEAR.
- Back-to-back operation: a new grant is possible in the first IDLE cycle after CLEAR.
- Fairness: if all requesters stay valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Pointer wrap: last_grant=NUM_REQ-1 resumes the scan at 0.
- A requester that drops valid before its handshake loses the grant; no state changes.
- flush_i=1 in any non-IDLE state: next state is CLEAR, core_start_o and out_valid_o are suppressed that cycle, rr pointer is retained.
- flush_i=1 in IDLE: req_ready_o is forced to 0 and the state stays IDLE. flush_i wins over a simultaneous handshake.
- flush_i asserted during CLEAR: stays on the IDLE path.
- reset mid-operation: immediate return to reset values; no clear pulse is issued (the latch has its own reset).

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in WAIT and resets on entering WAIT.
  - If it reaches TIMEOUT_CYCLES without core_done_i, the block goes to CLEAR and sets a sticky timeout_err_o output (1 bit).
  - timeout_err_o clears only on reset.
  - core_done_i in the same cycle the counter reaches the limit takes precedence (normal OUT path).
- Without the macro: no counter, no timeout_err_o port, and WAIT holds indefinitely.

Test Plan:
- Single request: req_valid_i=2'b01 with block 0x00112233445566778899AABBCCDDEEFF, core_done_i 3 cycles after START, out_ready_i=1. Expect latch_valid_o one cycle after the handshake, core_start_o the next cycle, out_valid_o with tag=0, latch_clear_o after OUT, busy_o low again 8 cycles after the handshake.
- Both requesters continuously valid for 4 blocks: grants 1,0,1,0 (pointer starts at 0 after reset), out_tag_o matches each grant, req_ready_o never has 2 bits set.
- Consumer backpressure: out_ready_i held 0 for 10 cycles. Expect out_valid_o and out_tag_o stable, no latch_clear_o, no new req_ready_o until out_ready_i=1.
- flush_i pulsed in WAIT: next cycle latch_clear_o=1 and no out_valid_o. A later core_done_i is ignored. The next grant goes to the other requester.
- flush_i and req_valid_i asserted together in IDLE: req_ready_o=0 and state stays IDLE. Reset asserted in OUT: all outputs at reset values the same cycle.
- With AES_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no core_done_i: CLEAR after 8 WAIT cycles and timeout_err_o=1 stays set. A second run with core_done_i on cycle 8 completes normally.

Source files
------------

// File: rtl/aes_latch_arbiter.sv
// ---------------------------------------------------------------------------
// aes_latch_arbiter
//
// Shares a single 128-bit AES block latch and its downstream core among
// NUM_REQ requesters. A round-robin arbiter picks one requester in IDLE. Its
// block is registered toward the latch and loaded, and the core is started.
// The arbiter then waits for completion and presents the result to the
// consumer, tagged with the requester index. Finally it clears the latch.
//
// Optional feature (macro AES_ARB_TIMEOUT_EN): a WAIT-state watchdog. If the
// core does not finish within TIMEOUT_CYCLES, the block aborts to CLEAR and
// raises a sticky timeout_err_o. Only reset clears timeout_err_o.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   req_valid_i     per-requester block valid
//   req_data_i      flattened blocks, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o     per-requester accept (one-hot or zero)
//   latch_d_o       registered block driven to the latch data input
//   latch_valid_o   latch load strobe
//   latch_clear_o   latch clear strobe
//   core_start_o    one-cycle core start pulse
//   core_done_i     core completion pulse (sampled in WAIT only)
//   out_valid_o     result available (data is read from the latch output)
//   out_ready_i     consumer accept
//   out_tag_o       requester index of the current result
//   flush_i         synchronous abort
//   timeout_err_o   sticky watchdog error (AES_ARB_TIMEOUT_EN only)
//   busy_o          high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module aes_latch_arbiter #(
    parameter int WIDTH          = 128,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int TAG_W         = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]         latch_d_o,
    output logic                     latch_valid_o,
    output logic                     latch_clear_o,
    output logic                     core_start_o,
    input  logic                     core_done_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [TAG_W-1:0]         out_tag_o,
    input  logic                     flush_i,
`ifdef AES_ARB_TIMEOUT_EN
    output logic                     timeout_err_o,
`endif
    output logic                     busy_o
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("aes_latch_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_OUT,
        ST_CLEAR
    } state_e;

    state_e             state_q, state_d;
    // The last grant is both the round-robin pointer and the result tag.
    // Both always take the same value, so a single register serves for both.
    logic [TAG_W-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic [TAG_W-1:0]   scan_idx;
    logic [TAG_W-1:0]   win_idx;
    logic               win_found;
    logic [WIDTH-1:0]   win_data;
    logic               handshake;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               timeout_err_q, timeout_err_d;
`endif

    // Round-robin scan. It starts one past the last grant and wraps at
    // NUM_REQ-1, so NUM_REQ need not be a power of two.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = (grant_q == TAG_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = (scan_idx == TAG_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    // Block mux using constant part-select bases.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == TAG_W'(i)) begin
                win_data = req_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Offer the grant only in IDLE. Flush and reset both suppress it, so
    // flush beats a simultaneous handshake.
    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_IDLE && win_found && !flush_i && !reset) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    assign handshake = |(req_valid_i & req_ready_o);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        data_d        = data_q;
        latch_valid_o = 1'b0;
        latch_clear_o = 1'b0;
        core_start_o  = 1'b0;
        out_valid_o   = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
        // The count restarts from zero each time WAIT is entered.
        wait_cnt_d    = (state_q == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;
        timeout_err_d = timeout_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d = ST_LOAD;
                    grant_d = win_idx;
                    data_d  = win_data;
                end
            end
            ST_LOAD: begin
                latch_valid_o = 1'b1;
                state_d       = flush_i ? ST_CLEAR : ST_START;
            end
            ST_START: begin
                if (flush_i) begin
                    state_d = ST_CLEAR;
                end else begin
                    core_start_o = 1'b1;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = ST_CLEAR;
                end else if (core_done_i) begin
                    // Completion wins over a watchdog expiry in the same cycle.
                    state_d = ST_OUT;
`ifdef AES_ARB_TIMEOUT_EN
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_CLEAR;
                    timeout_err_d = 1'b1;
`endif
                end
            end
            ST_OUT: begin
                if (flush_i) begin
                    state_d = ST_CLEAR;
                end else begin
                    out_valid_o = 1'b1;
                    if (out_ready_i) begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                latch_clear_o = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            // NOTE: the block register is reset too, because downstream
            // logic expects latch_d_o to read zero out of reset.
            data_q        <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register updates
            // from pre-edge values.
            state_q       <= state_d;
            grant_q       <= grant_d;
            data_q        <= data_d;
`ifdef AES_ARB_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign latch_d_o = data_q;
    assign out_tag_o = grant_q;
    assign busy_o    = (state_q != ST_IDLE);
`ifdef AES_ARB_TIMEOUT_EN
    assign timeout_err_o = timeout_err_q;
`endif

endmodule

// File: tb/tb_aes_latch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aes_latch_arbiter
//
// Directed testbench for aes_latch_arbiter (NUM_REQ=2, WIDTH=128). The
// expected values are worked out by hand from the cycle-level protocol.
// The bench drives inputs and samples outputs on the falling clock edge,
// away from the active rising edge. The watchdog section is compiled only
// when AES_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_aes_latch_arbiter;

    localparam int WIDTH   = 128;
    localparam int NUM_REQ = 2;
    localparam logic [WIDTH-1:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [WIDTH-1:0] BLK_B = 128'hFFEEDDCCBBAA99887766554433221100;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         latch_d;
    logic                     latch_valid;
    logic                     latch_clear;
    logic                     core_start;
    logic                     core_done;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_tag;
    logic                     flush;
    logic                     busy;
`ifdef AES_ARB_TIMEOUT_EN
    logic                     timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    aes_latch_arbiter #(
        .WIDTH          (WIDTH),
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .latch_d_o     (latch_d),
        .latch_valid_o (latch_valid),
        .latch_clear_o (latch_clear),
        .core_start_o  (core_start),
        .core_done_i   (core_done),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_tag_o     (out_tag),
        .flush_i       (flush),
`ifdef AES_ARB_TIMEOUT_EN
        .timeout_err_o (timeout_err),
`endif
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {latch_valid, core_start, out_valid, latch_clear, busy}
    function automatic logic [4:0] strobes();
        return {latch_valid, core_start, out_valid, latch_clear, busy};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One full 6-cycle transaction from IDLE with out_ready=1.
    task automatic run_block(input logic exp_g, input logic [WIDTH-1:0] exp_d);
        logic [1:0] exp_rdy;
        exp_rdy         = '0;
        exp_rdy[exp_g]  = 1'b1;
        check("rr_ready", 128'(req_ready), 128'(exp_rdy));
        tick();
        check("rr_load", 128'(strobes()), 128'(5'b10001));
        check("rr_latch_d", 128'(latch_d), 128'(exp_d));
        tick();
        check("rr_start", 128'(strobes()), 128'(5'b01001));
        tick();
        core_done = 1'b1;
        check("rr_wait", 128'(strobes()), 128'(5'b00001));
        tick();
        core_done = 1'b0;
        check("rr_out", 128'(strobes()), 128'(5'b00101));
        check("rr_tag", 128'(out_tag), 128'(exp_g));
        check("rr_no_ready_out", 128'(req_ready), 128'(2'b00));
        tick();
        check("rr_clear", 128'(strobes()), 128'(5'b00011));
        check("rr_no_ready_clr", 128'(req_ready), 128'(2'b00));
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_data  = {BLK_B, BLK_A};
        core_done = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        #2 reset  = 1'b1;
        #2;
        check("reset_strobes", 128'(strobes()), 128'(5'b00000));
        check("reset_latch_d", 128'(latch_d), 128'(0));
        check("reset_tag", 128'(out_tag), 128'(0));
        check("reset_ready", 128'(req_ready), 128'(2'b00));
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Single request from requester 0; core_done three cycles after START.
        req_valid = 2'b01;
        #1;
        check("t1_ready", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid = 2'b00;
        check("t1_load", 128'(strobes()), 128'(5'b10001));
        check("t1_latch_d", 128'(latch_d), 128'(BLK_A));
        tick();
        check("t1_start", 128'(strobes()), 128'(5'b01001));
        tick();
        check("t1_wait1", 128'(strobes()), 128'(5'b00001));
        tick();
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("t1_out", 128'(strobes()), 128'(5'b00101));
        check("t1_tag", 128'(out_tag), 128'(0));
        tick();
        check("t1_clear", 128'(strobes()), 128'(5'b00011));
        tick();
        check("t1_idle", 128'(strobes()), 128'(5'b00000));

        // Fairness and pointer wrap: both requesters always valid.
        req_valid = 2'b11;
        #1;
        run_block(1'b1, BLK_B);
        run_block(1'b0, BLK_A);
        run_block(1'b1, BLK_B);
        run_block(1'b0, BLK_A);

        // Consumer backpressure: the last grant was 0, so requester 1 wins.
        out_ready = 1'b0;
        #1;
        check("bp_ready", 128'(req_ready), 128'(2'b10));
        tick();
        tick();
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 128'({strobes(), out_tag, req_ready}), 128'({5'b00101, 1'b1, 2'b00}));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release", 128'(strobes()), 128'(5'b00101));
        tick();
        check("bp_clear", 128'(strobes()), 128'(5'b00011));
        tick();

        // Flush in WAIT, grant 0 (last grant was 1).
        check("fl_ready", 128'(req_ready), 128'(2'b01));
        tick();
        tick();
        tick();
        flush = 1'b1;
        #1;
        check("fl_wait", 128'(strobes()), 128'(5'b00001));
        tick();
        flush     = 1'b0;
        req_valid = 2'b00;
        core_done = 1'b1;
        check("fl_clear", 128'(strobes()), 128'(5'b00011));
        tick();
        check("fl_idle_done_ign", 128'(strobes()), 128'(5'b00000));
        tick();
        check("fl_idle_done_ign2", 128'(strobes()), 128'(5'b00000));
        core_done = 1'b0;
        req_valid = 2'b11;
        #1;
        check("fl_next_other", 128'(req_ready), 128'(2'b10));

        // Flush together with valid requests in IDLE.
        flush = 1'b1;
        #1;
        check("fi_ready", 128'(req_ready), 128'(2'b00));
        tick();
        check("fi_stay_idle", 128'(strobes()), 128'(5'b00000));
        flush = 1'b0;
        #1;
        check("fi_ready_after", 128'(req_ready), 128'(2'b10));
        tick();
        check("rs_latch_d", 128'(latch_d), 128'(BLK_B));
        tick();
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("rs_out", 128'({strobes(), out_tag}), 128'({5'b00101, 1'b1}));

        // Reset in OUT takes effect immediately.
        #1 reset = 1'b1;
        #1;
        check("rs_strobes", 128'(strobes()), 128'(5'b00000));
        check("rs_latch_d0", 128'(latch_d), 128'(0));
        check("rs_tag0", 128'(out_tag), 128'(0));
        check("rs_ready0", 128'(req_ready), 128'(2'b00));
        tick();
        reset = 1'b0;
        #1;
        check("rs_ptr_zero", 128'(req_ready), 128'(2'b10));
        req_valid = 2'b00;
        tick();

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog: no completion for 8 WAIT cycles.
        check("to_err_init", 128'(timeout_err), 128'(0));
        req_valid = 2'b01;
        #1;
        check("to_ready", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        for (int i = 1; i <= 8; i++) begin
            check("to_wait", 128'(strobes()), 128'(5'b00001));
            tick();
        end
        check("to_clear", 128'(strobes()), 128'(5'b00011));
        check("to_err_set", 128'(timeout_err), 128'(1));
        tick();
        check("to_err_sticky", 128'({strobes(), timeout_err}), 128'({5'b00000, 1'b1}));

        // Completion on the 8th WAIT cycle wins over the watchdog.
        req_valid = 2'b01;
        #1;
        check("to2_ready", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("to2_out", 128'(strobes()), 128'(5'b00101));
        tick();
        check("to2_clear", 128'(strobes()), 128'(5'b00011));
        tick();
        check("to2_err_sticky", 128'(timeout_err), 128'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
